// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART serial transmitter. It sends a start bit, DATA_WIDTH
// data bits (LSB first), an optional parity bit and a stop bit. Each bit is
// held for `prescale` CLK cycles, using the value latched when the word was
// accepted.
// Optional feature: define UART_TX_PARITY_EN to add the par_typ port and
// the PARITY state (0 = even, 1 = odd).
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [5:0]            prescale,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
`ifdef UART_TX_PARITY_EN
    input  logic                  par_typ,
`endif
    output logic                  tx_out,
    output logic                  busy
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                state_q, state_d;
    logic [5:0]            edge_cnt_q, edge_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [5:0]            prescale_q, prescale_d;
    logic                  tx_out_q, tx_out_d;
    logic                  terminal;
`ifdef UART_TX_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    // The current bit period ends on the last cycle of the latched prescale.
    assign terminal = (edge_cnt_q == (prescale_q - 6'd1));

    // Next-state logic: accept a word in IDLE, then step through the bit periods.
    always_comb begin
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        prescale_d = prescale_q;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        if (state_q != IDLE) begin
            edge_cnt_d = terminal ? 6'd0 : (edge_cnt_q + 6'd1);
        end
        case (state_q)
            IDLE: begin
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
                if (data_valid) begin
                    shift_d    = p_data;
                    prescale_d = (prescale == 6'd0) ? 6'd1 : prescale;
`ifdef UART_TX_PARITY_EN
                    parity_d   = (^p_data) ^ par_typ;
`endif
                    state_d    = START;
                end
            end
            START: begin
                if (terminal) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (terminal) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (terminal) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (terminal) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The line level is chosen from the next state, so the pin is driven by a flop.
    always_comb begin
        tx_out_d = 1'b1;
        case (state_d)
            START:   tx_out_d = 1'b0;
            DATA:    tx_out_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_out_d = parity_d;
`endif
            default: tx_out_d = 1'b1;
        endcase
    end

    // State and datapath registers. Reset aborts any frame and idles the line high.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            prescale_q <= 6'd1;
            tx_out_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            prescale_q <= prescale_d;
            tx_out_q   <= tx_out_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign tx_out = tx_out_q;
    assign busy   = (state_q != IDLE);

endmodule
